// File: rtl/jtframe_scroll_tilemap.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_scroll_tilemap
// Brief   : Scrollable tile map pixel generator. Combines the video counters
//           with per-line scroll to address tile VRAM, requests tile graphics
//           from the ROM slot once per 8-pixel group and serialises the
//           planar data into {palette, colour index} pixels.
// Revision: 1.0 - initial release
// ============================================================================
module jtframe_scroll_tilemap #(
  parameter int SIZE      = 8,
  parameter int BPP       = 4,
  parameter int CW        = 12,
  parameter int PW        = 8,
  parameter int MAP_HW    = 9,
  parameter int MAP_VW    = 9,
  parameter int VA        = MAP_HW + MAP_VW - 2 * ((SIZE == 16) ? 4 : 3),
  parameter int VR        = CW + ((SIZE == 16) ? 4 : 3) + ((SIZE == 16) ? 1 : 0),
  parameter bit XOR_HFLIP = 1'b0,
  parameter bit XOR_VFLIP = 1'b0
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                pxl_cen,
  input  logic [MAP_HW-1:0]   hdump,
  input  logic [MAP_VW-1:0]   vdump,
  input  logic                blankn,
  input  logic                flip,
  input  logic [MAP_HW-1:0]   hscr,
  input  logic [MAP_VW-1:0]   vscr,
  output logic [VA-1:0]       vram_addr,
  input  logic [CW-1:0]       code,
  input  logic [PW-BPP-1:0]   pal,
  input  logic                hflip,
  input  logic                vflip,
  output logic [VR-1:0]       rom_addr,
  output logic                rom_cs,
  input  logic                rom_ok,
  input  logic [8*BPP-1:0]    rom_data,
  output logic                miss,
  output logic [PW-1:0]       pxl
);

  localparam int VW   = (SIZE == 16) ? 4 : 3;
  localparam int DW   = 8 * BPP;
  localparam int PALW = PW - BPP;

  logic [MAP_HW-1:0] hscr_l;
  logic [MAP_VW-1:0] vscr_l;
  logic [MAP_HW-1:0] hscr_cur;
  logic [MAP_VW-1:0] vscr_cur;
  logic [MAP_HW-1:0] heff;
  logic [MAP_VW-1:0] veff;
  logic              scr_latch;
  logic              boundary;
  logic              hf_eff;
  logic              vf_eff;
  logic [VR-1:0]     addr_nx;

  logic [PALW-1:0]   nx_pal;
  logic [PALW-1:0]   cur_pal;
  logic              nx_hf;
  logic              cur_hf;
  logic [DW-1:0]     shift;
  logic [DW-1:0]     shift_nx;
  logic [BPP-1:0]    index;

  // Scroll is sampled at the start of each line; when that coincides with a
  // group boundary, the freshly presented scroll must already steer the fetch,
  // so the coordinates are built from the next-value of the latches.
  assign scr_latch = pxl_cen && (hdump == '0);
  assign hscr_cur  = scr_latch ? hscr : hscr_l;
  assign vscr_cur  = scr_latch ? vscr : vscr_l;
  assign heff      = hdump + hscr_cur;
  assign veff      = vdump + vscr_cur;
  assign vram_addr = {veff[MAP_VW-1:VW], heff[MAP_HW-1:VW]};
  assign boundary  = pxl_cen && (heff[2:0] == 3'd0);

  assign hf_eff = XOR_HFLIP ? (hflip ^ flip) : hflip;
  assign vf_eff = XOR_VFLIP ? (vflip ^ flip) : vflip;

  // 16x16 tiles are fetched as two 8-pixel halves; the half select follows
  // the horizontal flip so a flipped tile fetches its right half first.
  generate
    if (SIZE == 16) begin : g_half
      assign addr_nx = {code, heff[3] ^ hf_eff, veff[VW-1:0] ^ {VW{vf_eff}}};
    end else begin : g_full
      assign addr_nx = {code, veff[VW-1:0] ^ {VW{vf_eff}}};
    end
  endgenerate

  // Per-plane shift: each byte moves independently so planes never mix.
  always_comb begin
    shift_nx = shift;
    for (int n = 0; n < BPP; n++) begin
      if (cur_hf) shift_nx[8*n +: 8] = {1'b0, shift[8*n+1 +: 7]};
      else        shift_nx[8*n +: 8] = {shift[8*n +: 7], 1'b0};
    end
  end

  // Colour index taken from the leading edge of every plane byte.
  always_comb begin
    index = '0;
    for (int n = 0; n < BPP; n++) begin
      index[n] = cur_hf ? shift[8*n] : shift[8*n+7];
    end
  end

  // Line-start scroll latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hscr_l <= '0;
      vscr_l <= '0;
    end else if (scr_latch) begin
      hscr_l <= hscr;
      vscr_l <= vscr;
    end
  end

  // Group fetch: issue the next ROM request and pipeline the tile attributes
  // one group behind so they line up with the data being serialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      nx_pal   <= '0;
      nx_hf    <= 1'b0;
      cur_pal  <= '0;
      cur_hf   <= 1'b0;
    end else if (boundary) begin
      rom_cs   <= blankn;
      rom_addr <= addr_nx;
      nx_pal   <= pal;
      nx_hf    <= hf_eff;
      cur_pal  <= nx_pal;
      cur_hf   <= nx_hf;
    end
  end

  // Pixel shifter: load the previous request's data at a boundary (zeros and
  // a miss pulse when the ROM was late), otherwise shift one pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      miss  <= 1'b0;
    end else begin
      miss <= 1'b0;
      if (boundary && rom_cs) begin
        if (rom_ok) begin
          shift <= rom_data;
        end else begin
          shift <= '0;
          miss  <= 1'b1;
        end
      end else if (pxl_cen) begin
        shift <= shift_nx;
      end
    end
  end

  // Output register towards the colour mixer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pxl <= '0;
    else     pxl <= {cur_pal, index};
  end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_scroll_tilemap.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtframe_scroll_tilemap
// Brief   : Directed self-checking bench for jtframe_scroll_tilemap. One
//           instance uses 8x8 tiles at 4 bpp, a second 16x16 tiles at 8 bpp;
//           both share the timing and VRAM stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jtframe_scroll_tilemap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        blankn = 1'b1;
  logic        flip = 1'b0;
  logic        hflip = 1'b0;
  logic        vflip = 1'b0;
  logic        rom_ok = 1'b1;
  logic [8:0]  hdump = '0;
  logic [8:0]  vdump = '0;
  logic [8:0]  hscr = '0;
  logic [8:0]  vscr = '0;
  logic [11:0] code = '0;
  logic [11:0] code_base = '0;
  logic [3:0]  pal = '0;
  logic [31:0] rom_data1 = '0;
  logic [63:0] rom_data2 = '0;

  logic [11:0] vram_addr1;
  logic [14:0] rom_addr1;
  logic        rom_cs1;
  logic        miss1;
  logic [7:0]  pxl1;

  logic [9:0]  vram_addr2;
  logic [16:0] rom_addr2;
  logic        rom_cs2;
  logic        miss2;
  logic [11:0] pxl2;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [3:0]  seq [8];
  logic [7:0]  onehot;
  logic        nz;

  always #5 clk = ~clk;

  jtframe_scroll_tilemap #(
    .SIZE(8), .BPP(4), .CW(12), .PW(8), .MAP_HW(9), .MAP_VW(9)
  ) dut8 (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .hdump(hdump), .vdump(vdump),
    .blankn(blankn), .flip(flip), .hscr(hscr), .vscr(vscr),
    .vram_addr(vram_addr1), .code(code), .pal(pal), .hflip(hflip), .vflip(vflip),
    .rom_addr(rom_addr1), .rom_cs(rom_cs1), .rom_ok(rom_ok), .rom_data(rom_data1),
    .miss(miss1), .pxl(pxl1)
  );

  jtframe_scroll_tilemap #(
    .SIZE(16), .BPP(8), .CW(12), .PW(12), .MAP_HW(9), .MAP_VW(9)
  ) dut16 (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .hdump(hdump), .vdump(vdump),
    .blankn(blankn), .flip(flip), .hscr(hscr), .vscr(vscr),
    .vram_addr(vram_addr2), .code(code), .pal(pal), .hflip(hflip), .vflip(vflip),
    .rom_addr(rom_addr2), .rom_cs(rom_cs2), .rom_ok(rom_ok), .rom_data(rom_data2),
    .miss(miss2), .pxl(pxl2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel-enable edge: the tile code tracks the column so fetches are traceable.
  task automatic cen_half();
    code    = code_base + 12'(hdump);
    pxl_cen = 1'b1;
    @(posedge clk);
    #1;
    pxl_cen = 1'b0;
  endtask

  // Idle clock between pixels; the counter advances here.
  task automatic idle_half();
    hdump = hdump + 9'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cen_half();
    idle_half();
  endtask

  task automatic run_to(input int h);
    while (int'(hdump) < h) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seq = '{4'h7, 4'h6, 4'h5, 4'h4, 4'hB, 4'hA, 4'h9, 4'h8};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_cs",    64'(rom_cs1),   64'h0);
    chk("rst_rom_addr",  64'(rom_addr1), 64'h0);
    chk("rst_miss",      64'(miss1),     64'h0);
    chk("rst_pxl",       64'(pxl1),      64'h0);
    chk("rst_pxl16",     64'(pxl2),      64'h0);
    rst = 1'b0;

    // Basic fetch and serialisation, no scroll
    code_base = 12'h005; pal = 4'hA; rom_ok = 1'b1;
    tick();
    chk("t1_rom_cs",   64'(rom_cs1),   64'h1);
    chk("t1_rom_addr", 64'(rom_addr1), 64'h028);
    run_to(8);
    chk("t1_pxl_before_group", 64'(pxl1), 64'h00);
    rom_data1 = 32'h0000_0080;
    cen_half();
    chk("t1_miss_quiet", 64'(miss1), 64'h0);
    idle_half();
    chk("t1_pxl_first",     64'(pxl1),      64'hA1);
    chk("t1_rom_addr_next", 64'(rom_addr1), 64'h068);
    for (int p = 1; p < 8; p++) begin
      tick();
      chk("t1_pxl_tail", 64'(pxl1), 64'hA0);
    end

    // Horizontal scroll latched at line start
    hdump = '0; hscr = 9'd3; code_base = 12'h100;
    tick();
    run_to(4);
    chk("t3_vram_h4", 64'(vram_addr1), 64'h000);
    tick();
    chk("t3_vram_h5", 64'(vram_addr1), 64'h001);
    tick();
    chk("t3_addr_h5", 64'(rom_addr1), 64'h0828);
    run_to(13);
    chk("t3_addr_h12", 64'(rom_addr1), 64'h0828);
    tick();
    chk("t3_addr_h13", 64'(rom_addr1), 64'h0868);
    run_to(22);
    chk("t3_addr_h21", 64'(rom_addr1), 64'h08A8);
    run_to(40);
    hscr = 9'd0;
    tick();
    chk("t3_midline_hscr", 64'(rom_addr1), 64'h0928);
    run_to(46);
    chk("t3_addr_h45", 64'(rom_addr1), 64'h0968);

    // Vertical scroll wrap with vertical flip
    hdump = '0; hscr = 9'd0; vscr = 9'h1FE; vdump = 9'd4; vflip = 1'b1;
    code_base = 12'h200;
    tick();
    chk("t4_addr_vflip", 64'(rom_addr1),      64'h1005);
    chk("t4_addr_lsb",   64'(rom_addr1[2:0]), 64'h5);
    chk("t4_addr16",     64'(rom_addr2),      64'h0400D);
    vflip = 1'b0;

    // 16x16, 8 bpp, horizontal flip
    hdump = '0; vscr = 9'd0; vdump = 9'd0; hflip = 1'b1; pal = 4'h5;
    code_base = 12'h300;
    tick();
    chk("t5_addr16_half", 64'(rom_addr2),    64'h06010);
    chk("t5_addr16_bit4", 64'(rom_addr2[4]), 64'h1);
    run_to(8);
    rom_data2 = 64'h8040_2010_0804_0201;
    tick();
    chk("t5_pxl16_first", 64'(pxl2),      64'h501);
    chk("t5_addr16_next", 64'(rom_addr2), 64'h06100);
    for (int p = 1; p < 8; p++) begin
      tick();
      onehot = 8'(1 << p);
      chk("t5_pxl16_seq", 64'(pxl2), 64'({4'h5, onehot}));
    end

    // Late ROM data at one boundary
    hdump = '0; hflip = 1'b0; pal = 4'h3; code_base = 12'h000;
    rom_data1 = 32'h0FF0_CCAA; rom_ok = 1'b1;
    tick();
    run_to(8);
    rom_ok = 1'b0;
    cen_half();
    chk("t6_miss_high", 64'(miss1), 64'h1);
    idle_half();
    chk("t6_miss_low", 64'(miss1), 64'h0);
    rom_ok = 1'b1;
    chk("t6_miss_pxl", 64'(pxl1), 64'h30);
    for (int p = 1; p < 8; p++) begin
      tick();
      chk("t6_miss_pxl", 64'(pxl1), 64'h30);
    end
    for (int p = 0; p < 4; p++) begin
      tick();
      chk("t6_recover", 64'(pxl1), 64'({4'h3, seq[p]}));
    end

    // Asynchronous reset while shifting
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_cs",     64'(rom_cs1),   64'h0);
    chk("t7_rst_addr",   64'(rom_addr1), 64'h0);
    chk("t7_rst_miss",   64'(miss1),     64'h0);
    chk("t7_rst_pxl",    64'(pxl1),      64'h00);
    chk("t7_rst_pxl16",  64'(pxl2),      64'h000);
    chk("t7_rst_addr16", 64'(rom_addr2), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nz = 1'b0;
    while (int'(hdump) < 32) begin
      tick();
      if (pxl1[3:0] != 4'h0) nz = 1'b1;
    end
    chk("t7_no_early_pxl", 64'(nz), 64'h0);
    tick();
    chk("t7_first_pxl", 64'(pxl1), 64'h37);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtframe_scroll_tilemap.md
Name: jtframe_scroll_tilemap

Overview:
- Scrollable tile map generator; successor to the fixed, no-scroll tilemap block.
- Adds per-line horizontal/vertical scroll, 4 or 8 bpp pixel data, half-tile flip for 16x16 tiles, and rom_ok checking with a miss flag.
- Sits between the video timing generator, tile VRAM and the SDRAM ROM slot; feeds the colour mixer one pixel per pxl_cen.

Parameters:
- SIZE, 8, tile size in pixels: 8 or 16.
- BPP, 4, bits per pixel: 4 or 8.
- CW, 12, tile code width.
- PW, 8, pixel output width = palette bits + BPP; PW > BPP.
- MAP_HW, 9, map width in pixels as log2.
- MAP_VW, 9, map height in pixels as log2.
- VA, MAP_HW+MAP_VW-2*VW, VRAM address width. VW=3 for SIZE 8, 4 for SIZE 16.
- VR, CW+VW+(SIZE==16), ROM address width.
- XOR_HFLIP, 0: 1 = effective hflip is hflip^flip.
- XOR_VFLIP, 0: 1 = effective vflip is vflip^flip.

Ports:
- rst  in  1  asynchronous, active-high reset
- clk  in  1  clock
- pxl_cen  in  1  pixel clock enable
- hdump  in  MAP_HW  horizontal counter
- vdump  in  MAP_VW  vertical counter
- blankn  in  1  0 = no ROM requests issued
- flip  in  1  screen flip
- hscr  in  MAP_HW  horizontal scroll
- vscr  in  MAP_VW  vertical scroll
- vram_addr  out  VA  tile map address, combinational
- code  in  CW  tile code from VRAM
- pal  in  PW-BPP  palette from VRAM
- hflip  in  1  per-tile horizontal flip
- vflip  in  1  per-tile vertical flip
- rom_addr  out  VR  tile ROM address
- rom_cs  out  1  ROM request
- rom_ok  in  1  ROM data valid
- rom_data  in  8*BPP  one byte per plane, plane 0 in bits [7:0]
- miss  out  1  one-clock pulse when data was not ready
- pxl  out  PW  {palette, colour index}

Behaviour:
- Scroll latch: on pxl_cen with hdump==0, hscr_l<=hscr and vscr_l<=vscr. Both are cleared by reset. Mid-line writes have no effect until the next line.
- Effective coordinates, modulo wrap with no carry out:
  - heff = hdump+hscr_l, MAP_HW bits.
  - veff = vdump+vscr_l, MAP_VW bits.
- vram_addr = {veff[MAP_VW-1:VW], heff[MAP_HW-1:VW]}, combinational.
- Group boundary: pxl_cen && heff[2:0]==0. On each boundary, all at once:
  - rom_cs <= blankn.
  - rom_addr <= {code, [heff[3]^hf for SIZE 16], veff[VW-1:0]^{VW{vf}}}.
  - nx_pal/nx_hf capture pal and the effective hflip.
  - cur_pal/cur_hf <= nx_pal/nx_hf.
  - Shifter loads rom_data if rom_ok, otherwise loads all zeros and pulses miss for one clock. The shifter is not loaded, and miss does not pulse, if rom_cs was 0.
- Non-boundary pxl_cen: shifter shifts by one bit per plane byte. Left shift when cur_hf=0, right shift when cur_hf=1.
- pxl = {cur_pal, index}:
  - index bit n = bit 7 of plane byte n when cur_hf=0.
  - index bit n = bit 0 of plane byte n when cur_hf=1.
- Latency: a pixel appears 8 pixel clocks after its VRAM attributes are sampled (one group), plus one clk register. This latency is fixed regardless of scroll.
- Fine scroll: the first group of a line after the latch may be partial. This is accepted; the driver blanks the left border.
- blankn=0: rom_cs falls at the next boundary. The shifter then holds and keeps shifting to zero; pxl colour index becomes 0 after at most 8 pixels.
- rom_ok is sampled only at boundaries.
- Reset values, asynchronous, at any time including mid-group: rom_cs=0, rom_addr=0, miss=0, pxl=0, shifter=0, pal/flip registers=0, scroll latches=0. After reset the first valid pixel needs two boundaries.
- Simultaneous hdump==0 and boundary: the boundary uses the newly latched scroll. heff is computed from the next-value mux.

Test Plan:
- SIZE=8, BPP=4, hscr=vscr=0. Tile 0x005 at map (0,0), plane bytes 0x80,0,0,0. Expected: rom_addr=0x028 with vdump=0; pxl index pattern 1,0,0,0,0,0,0,0 starting 8 pixels after the group start.
- hscr=3 latched at hdump=0. Expected: boundaries at hdump=5,13,21; vram_addr low field advances at hdump=5. Changing hscr at hdump=40 has no effect until the next line.
- vscr=0x1FE, vdump=4. Expected: veff=2 (wrap); vflip=1 gives rom_addr[2:0]=5.
- SIZE=16, BPP=8, hflip=1, heff in the left half. Expected: rom_addr[4]=1; pxl index comes from bit 0 of the 8 plane bytes.
- rom_ok=0 at one boundary. Expected: miss high for exactly one clk; 8 pixels with index 0; the next group is normal.
- Assert rst during mid-line shifting. Expected: all outputs 0 immediately. After release, first non-zero pixel not before the second boundary.
